// File: rtl/decompressor_pkg.sv
// Shared definitions for the decompressor phase sequencer.
//   state_e            - sequencer FSM state encoding
//   PH_*               - fixed phase slot assignments (index 0 runs first)
//   DEF_TIMEOUT_CYCLES - default per-phase watchdog limit
//   PHASE_IDX_W        - width of a phase index (up to 8 phases)
package decompressor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam int PH_REORDER = 0;
  localparam int PH_YUV2RGB = 1;
  localparam int PH_VGA     = 2;
  localparam int PH_SPARE   = 3;

  localparam int DEF_TIMEOUT_CYCLES = 2000000;
  localparam int PHASE_IDX_W        = 3;
  localparam int MAX_PHASES         = 8;

endpackage

// File: rtl/next_phase_finder.sv
// Combinational search for the next enabled phase.
//   mask       - enabled phases
//   cur_idx    - currently running phase
//   from_start - 1: return lowest set bit; 0: lowest set bit strictly above cur_idx
//   nxt_idx    - resulting phase index (0 when not found)
//   found      - a qualifying bit exists
module next_phase_finder
  import decompressor_pkg::*;
#(
  parameter int NUM_PHASES = 4
) (
  input  logic [NUM_PHASES-1:0]  mask,
  input  logic [PHASE_IDX_W-1:0] cur_idx,
  input  logic                   from_start,
  output logic [PHASE_IDX_W-1:0] nxt_idx,
  output logic                   found
);

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt_idx = '0;
    found   = 1'b0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (PHASE_IDX_W'(i) > cur_idx))) begin
        nxt_idx = PHASE_IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_phase_sequencer.sv
// Runs the enabled decompressor phases one at a time and grants the shared
// SRAM port to the running phase. A watchdog aborts a hung phase.
//   clk, reset            - clock, async active-high reset
//   start, phase_mask     - begin a run over the enabled phases
//   busy, done, error     - run status (error is sticky until next start)
//   cur_phase             - index of the granted phase
//   phase_start/done      - per-phase handshake
//   ph_*                  - per-phase SRAM requests (packed, phase i at [i*W +: W])
//   ph_rdata              - SRAM read data broadcast to all phases
//   sram_*                - shared SRAM port
module sram_phase_sequencer
  import decompressor_pkg::*;
#(
  parameter int AW             = 20,
  parameter int DW             = 16,
  parameter int NUM_PHASES     = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TW             = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_PHASES-1:0]    phase_mask,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [2:0]               cur_phase,
  output logic [NUM_PHASES-1:0]    phase_start,
  input  logic [NUM_PHASES-1:0]    phase_done,
  input  logic [NUM_PHASES*AW-1:0] ph_raddr,
  input  logic [NUM_PHASES*AW-1:0] ph_waddr,
  input  logic [NUM_PHASES*DW-1:0] ph_wdata,
  input  logic [NUM_PHASES-1:0]    ph_wr_enable,
  output logic [DW-1:0]            ph_rdata,
  output logic [AW-1:0]            sram_raddr,
  input  logic [DW-1:0]            sram_rdata,
  output logic [AW-1:0]            sram_waddr,
  output logic [DW-1:0]            sram_wdata,
  output logic                     sram_wr_enable
);

  state_e                   state_q, state_d;
  logic [PHASE_IDX_W-1:0]   cur_q, cur_d;
  logic [NUM_PHASES-1:0]    mask_q, mask_d;
  logic [TW-1:0]            wdog_q, wdog_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     grant_q, grant_d;
  logic [NUM_PHASES-1:0]    pstart_q, pstart_d;

  logic [PHASE_IDX_W-1:0]   nxt_idx;
  logic                     nxt_found;
  logic [MAX_PHASES-1:0]    done_pad;

  // In IDLE the search runs on the incoming mask so LAUNCH follows start directly.
  next_phase_finder #(.NUM_PHASES(NUM_PHASES)) u_finder (
    .mask       ((state_q == ST_IDLE) ? phase_mask : mask_q),
    .cur_idx    (cur_q),
    .from_start (state_q == ST_IDLE),
    .nxt_idx    (nxt_idx),
    .found      (nxt_found)
  );

  assign done_pad = MAX_PHASES'(phase_done);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    mask_d  = mask_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = phase_mask;
          err_d   = 1'b0;
          if (nxt_found) begin
            cur_d   = nxt_idx;
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_LAUNCH: begin
        wdog_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
        // Completion takes priority over a coincident timeout.
        if (done_pad[cur_q]) begin
          state_d = ST_NEXT;
        end else if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_NEXT: begin
        if (nxt_found) begin
          cur_d   = nxt_idx;
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FINISH) || (state_d == ST_FAULT);
    grant_d  = (state_d == ST_LAUNCH) || (state_d == ST_RUN);
    pstart_d = (state_d == ST_LAUNCH) ? (NUM_PHASES'(1) << cur_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      mask_q   <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= 1'b0;
      pstart_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      mask_q   <= mask_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      pstart_q <= pstart_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign cur_phase   = cur_q;
  assign phase_start = pstart_q;

  // Unpack per-phase requests into full 8-entry tables so a 3-bit index is always legal.
  logic [AW-1:0] raddr_a [MAX_PHASES];
  logic [AW-1:0] waddr_a [MAX_PHASES];
  logic [DW-1:0] wdata_a [MAX_PHASES];
  logic [MAX_PHASES-1:0] wen_a;

  for (genvar i = 0; i < MAX_PHASES; i++) begin : g_unpack
    if (i < NUM_PHASES) begin : g_used
      assign raddr_a[i] = ph_raddr[i*AW +: AW];
      assign waddr_a[i] = ph_waddr[i*AW +: AW];
      assign wdata_a[i] = ph_wdata[i*DW +: DW];
      assign wen_a[i]   = ph_wr_enable[i];
    end else begin : g_pad
      assign raddr_a[i] = '0;
      assign waddr_a[i] = '0;
      assign wdata_a[i] = '0;
      assign wen_a[i]   = 1'b0;
    end
  end

  always_comb begin
    sram_raddr     = '0;
    sram_waddr     = '0;
    sram_wdata     = '0;
    sram_wr_enable = 1'b0;
    if (grant_q) begin
      sram_raddr     = raddr_a[cur_q];
      sram_waddr     = waddr_a[cur_q];
      sram_wdata     = wdata_a[cur_q];
      sram_wr_enable = wen_a[cur_q];
    end
  end

  assign ph_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_phase_sequencer.sv
module tb_sram_phase_sequencer;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int NP = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [NP-1:0]    phase_mask = '0;
  logic             busy, done, error;
  logic [2:0]       cur_phase;
  logic [NP-1:0]    phase_start;
  logic [NP-1:0]    phase_done;
  logic [NP*AW-1:0] ph_raddr = '0;
  logic [NP*AW-1:0] ph_waddr = '0;
  logic [NP*DW-1:0] ph_wdata = '0;
  logic [NP-1:0]    ph_wr_enable = '0;
  logic [DW-1:0]    ph_rdata;
  logic [AW-1:0]    sram_raddr, sram_waddr;
  logic [DW-1:0]    sram_rdata = '0;
  logic [DW-1:0]    sram_wdata;
  logic             sram_wr_enable;

  logic [NP-1:0] resp_done = '0;
  logic [NP-1:0] spur_done = '0;
  logic [NP-1:0] resp_en   = '1;
  assign phase_done = resp_done | spur_done;

  sram_phase_sequencer #(.AW(AW), .DW(DW), .NUM_PHASES(NP), .TIMEOUT_CYCLES(TO), .TW(24)) dut (
    .clk(clk), .reset(reset), .start(start), .phase_mask(phase_mask),
    .busy(busy), .done(done), .error(error), .cur_phase(cur_phase),
    .phase_start(phase_start), .phase_done(phase_done),
    .ph_raddr(ph_raddr), .ph_waddr(ph_waddr), .ph_wdata(ph_wdata),
    .ph_wr_enable(ph_wr_enable), .ph_rdata(ph_rdata),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .sram_wr_enable(sram_wr_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] pstart;
    logic          dn;
    logic          err;
    logic [2:0]    cur;
    logic          chk_cur;
    int            delta;
  } evt_t;

  evt_t exq[$];
  evt_t e_m;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic gnt_m = 1'b0;
  int   cur_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Random per-phase SRAM requests, changed just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      ph_raddr[i*AW +: AW] = AW'($urandom);
      ph_waddr[i*AW +: AW] = AW'($urandom);
      ph_wdata[i*DW +: DW] = DW'($urandom);
    end
    ph_wr_enable = NP'($urandom);
    sram_rdata   = DW'($urandom);
  end

  // Phase model: answers done 10 cycles after its start pulse when enabled.
  initial forever begin
    int idx;
    logic go;
    @(negedge clk);
    go = 1'b0;
    idx = 0;
    if (!reset) begin
      for (int i = 0; i < NP; i++)
        if (phase_start[i] && resp_en[i]) begin idx = i; go = 1'b1; end
    end
    if (go) begin
      repeat (10) @(posedge clk);
      #1 resp_done[idx] = 1'b1;
      @(posedge clk);
      #1 resp_done[idx] = 1'b0;
    end
  end

  // Monitor: pops expected events on every start/done pulse and checks the SRAM mux.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      gnt_m = 1'b0;
      continue;
    end
    if (done) gnt_m = 1'b0;
    if (phase_start != 0 || done) begin
      if (exq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got phase_start=%b done=%b expected no event at t=%0t",
                 phase_start, done, $time);
      end else begin
        e_m = exq.pop_front();
        chk("ev_phase_start", 64'(phase_start), 64'(e_m.pstart));
        chk("ev_done", 64'(done), 64'(e_m.dn));
        chk("ev_error", 64'(error), 64'(e_m.err));
        chk("ev_busy", 64'(busy), 64'(1'b1));
        if (e_m.chk_cur) chk("ev_cur_phase", 64'(cur_phase), 64'(e_m.cur));
        chk("ev_latency", 64'(cyc - last_cyc), 64'(e_m.delta));
      end
      last_cyc = cyc;
    end
    if (phase_start != 0) begin
      gnt_m = 1'b1;
      for (int i = 0; i < NP; i++) if (phase_start[i]) cur_m = i;
    end
    chk("sram_wr_enable", 64'(sram_wr_enable), 64'(gnt_m ? ph_wr_enable[cur_m] : 1'b0));
    chk("sram_raddr", 64'(sram_raddr), 64'(gnt_m ? ph_raddr[cur_m*AW +: AW] : '0));
    chk("sram_waddr", 64'(sram_waddr), 64'(gnt_m ? ph_waddr[cur_m*AW +: AW] : '0));
    chk("sram_wdata", 64'(sram_wdata), 64'(gnt_m ? ph_wdata[cur_m*DW +: DW] : '0));
    chk("ph_rdata", 64'(ph_rdata), 64'(sram_rdata));
    if (gnt_m && phase_done[cur_m]) gnt_m = 1'b0;
  end

  task automatic push(input logic [NP-1:0] ps, input logic dn, input logic er,
                      input logic [2:0] cu, input logic cc, input int d);
    evt_t e;
    e.pstart = ps; e.dn = dn; e.err = er; e.cur = cu; e.chk_cur = cc; e.delta = d;
    exq.push_back(e);
  endtask

  task automatic launch(input logic [NP-1:0] m);
    @(negedge clk);
    phase_mask = m;
    start = 1'b1;
    last_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exq.size() != 0 && n < 300);
    if (exq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending events expected 0", name, exq.size());
      exq.delete();
    end
  endtask

  task automatic post_idle(input string name, input logic exp_err);
    @(negedge clk);
    chk({name, "_busy_low"}, 64'(busy), 64'(1'b0));
    chk({name, "_done_low"}, 64'(done), 64'(1'b0));
    chk({name, "_error"}, 64'(error), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_phase_start", 64'(phase_start), 64'(0));
    chk("rst_cur_phase", 64'(cur_phase), 64'(0));
    chk("rst_sram_we", 64'(sram_wr_enable), 64'(0));
    chk("rst_sram_raddr", 64'(sram_raddr), 64'(0));
    chk("rst_sram_waddr", 64'(sram_waddr), 64'(0));
    chk("rst_sram_wdata", 64'(sram_wdata), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Two phases, each completing 10 cycles after its start.
    resp_en = '1;
    push(4'b0001, 0, 0, 3'd0, 1, 1);
    push(4'b0010, 0, 0, 3'd1, 1, 12);
    push(4'b0000, 1, 0, 3'd1, 1, 12);
    launch(4'b0011);
    drain("mask0011");
    post_idle("mask0011", 1'b0);

    // Sparse mask: phases 0 and 2 skipped.
    push(4'b0010, 0, 0, 3'd1, 1, 1);
    push(4'b1000, 0, 0, 3'd3, 1, 12);
    push(4'b0000, 1, 0, 3'd3, 1, 12);
    launch(4'b1010);
    drain("mask1010");
    post_idle("mask1010", 1'b0);

    // Empty mask: straight to done.
    push(4'b0000, 1, 0, 3'd0, 0, 1);
    launch(4'b0000);
    drain("mask0000");
    post_idle("mask0000", 1'b0);

    // Phase 0 hangs: fault after TO run cycles, phase 1 never launched.
    resp_en = 4'b1110;
    push(4'b0001, 0, 0, 3'd0, 1, 1);
    push(4'b0000, 1, 1, 3'd0, 1, TO + 1);
    launch(4'b0011);
    drain("timeout");
    post_idle("timeout", 1'b1);
    repeat (5) @(negedge clk);
    chk("error_sticky", 64'(error), 64'(1));
    resp_en = '1;
    push(4'b0000, 1, 0, 3'd0, 0, 1);
    launch(4'b0000);
    drain("error_clear");
    post_idle("error_clear", 1'b0);

    // Spurious done on a non-current phase and a start while busy.
    push(4'b0001, 0, 0, 3'd0, 1, 1);
    push(4'b0100, 0, 0, 3'd2, 1, 12);
    push(4'b0000, 1, 0, 3'd2, 1, 12);
    fork
      begin
        launch(4'b0101);
        drain("spurious");
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        spur_done  = 4'b0100;
        start      = 1'b1;
        phase_mask = 4'b1111;
        @(posedge clk);
        #1;
        spur_done  = '0;
        start      = 1'b0;
        phase_mask = 4'b0101;
      end
    join
    post_idle("spurious", 1'b0);

    // Reset in the middle of phase 1's run.
    resp_en = 4'b1101;
    push(4'b0010, 0, 0, 3'd1, 1, 1);
    launch(4'b0010);
    drain("pre_reset");
    repeat (5) @(negedge clk);
    chk("mid_run_busy", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_phase_start", 64'(phase_start), 64'(0));
    chk("async_rst_cur_phase", 64'(cur_phase), 64'(0));
    chk("async_rst_sram_we", 64'(sram_wr_enable), 64'(0));
    chk("async_rst_sram_raddr", 64'(sram_raddr), 64'(0));
    chk("async_rst_sram_wdata", 64'(sram_wdata), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    resp_en = '1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    push(4'b0001, 0, 0, 3'd0, 1, 1);
    push(4'b0000, 1, 0, 3'd0, 1, 12);
    launch(4'b0001);
    drain("post_reset_run");
    post_idle("post_reset_run", 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
